// File: rtl/canny_edge_morph_3x3_if.sv
// Pixel-stream bundle between the Canny edge chain and the morphology stage.
// The master drives the edge stream and mode; the slave returns the filtered stream.
interface canny_edge_morph_3x3_if;
  logic [1:0] morph_mode;
  logic       per_frame_vsync;
  logic       per_frame_href;
  logic       per_frame_clken;
  logic       per_img_bit;
  logic       post_frame_vsync;
  logic       post_frame_href;
  logic       post_frame_clken;
  logic       post_img_bit;

  modport master (
    output morph_mode, per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
    input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
  );

  modport slave (
    input  morph_mode, per_frame_vsync, per_frame_href, per_frame_clken, per_img_bit,
    output post_frame_vsync, post_frame_href, post_frame_clken, post_img_bit
  );
endinterface

// File: rtl/canny_edge_morph_3x3.sv
// 3x3 binary morphology (dilate / erode / bypass) on a 1-bit edge stream,
// using two line buffers, a sliding window and a frame-lock FSM; 2 clk latency.
module canny_edge_morph_3x3 #(
  parameter int IMG_WIDTH = 640,
  parameter int ADDR_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  canny_edge_morph_3x3_if.slave   pix_if
);

  typedef enum logic [0:0] {WAIT_VS, ACTIVE} state_t;

  localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_WIDTH - 1);

  state_t            state_q, state_d;
  logic              active;

  logic              vs_q, href_q, clken_q;
  logic [1:0]        mode_q;
  logic [ADDR_W-1:0] col_cnt_q, col_cnt_d;
  logic              ovf_q, ovf_d;
  logic [1:0]        row_cnt_q, row_cnt_d;

  logic              lb0_mem [0:IMG_WIDTH-1];
  logic              lb1_mem [0:IMG_WIDTH-1];

  logic [2:0]        win_top_q, win_mid_q, win_bot_q;
  logic [1:0]        row_s1_q, col_s1_q, mode_s1_q;
  logic              ovf_s1_q, bit_s1_q;

  logic              post_vs_q, post_href_q, post_clken_q, post_bit_q;
  logic              post_href_d, post_clken_d, post_bit_d;

  logic              vs_rise, href_rise, href_fall, pix;
  logic [ADDR_W-1:0] col_cur;
  logic              ovf_cur;
  logic [1:0]        row_cur;
  logic              lb0_rd, lb1_rd, result;

  // Window bit j is column c-2+j; row/column positions outside the frame read as 0,
  // so incomplete windows never dilate into stale data and always erode to 0.
  function automatic logic morph_fn(input logic [2:0] top, input logic [2:0] mid,
                                    input logic [2:0] bot, input logic [1:0] row,
                                    input logic [1:0] col, input logic erode);
    logic [2:0] cmask;
    logic [8:0] w;
    cmask = {1'b1, col >= 2'd1, col >= 2'd2};
    w = {(row >= 2'd2) ? (top & cmask) : 3'b000,
         (row >= 2'd1) ? (mid & cmask) : 3'b000,
         bot & cmask};
    return erode ? (&w) : (|w);
  endfunction

  assign vs_rise   = pix_if.per_frame_vsync & ~vs_q;
  assign href_rise = pix_if.per_frame_href & ~href_q;
  assign href_fall = ~pix_if.per_frame_href & href_q;
  assign pix       = pix_if.per_frame_clken & pix_if.per_frame_href;

  // Edge-triggered clears take effect for a pixel arriving on the edge cycle itself.
  assign col_cur = (vs_rise | href_rise) ? '0 : col_cnt_q;
  assign ovf_cur = (vs_rise | href_rise) ? 1'b0 : ovf_q;
  assign row_cur = vs_rise ? 2'd0 : row_cnt_q;

  assign lb0_rd = lb0_mem[col_cur];
  assign lb1_rd = lb1_mem[col_cur];

  always_comb begin
    col_cnt_d = col_cur;
    ovf_d     = ovf_cur;
    row_cnt_d = row_cur;
    if (pix && !ovf_cur) begin
      if (col_cur == COL_LAST) ovf_d = 1'b1;
      else                     col_cnt_d = col_cur + 1'b1;
    end
    if (href_fall && !vs_rise && row_cur != 2'd3) row_cnt_d = row_cur + 2'd1;
  end

  always_comb begin
    state_d = state_q;
    active  = 1'b0;
    case (state_q)
      WAIT_VS: if (vs_rise) state_d = ACTIVE;
      ACTIVE:  active = 1'b1;
      default: state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= WAIT_VS;
      vs_q      <= 1'b0;
      href_q    <= 1'b0;
      clken_q   <= 1'b0;
      mode_q    <= 2'b01;
      col_cnt_q <= '0;
      ovf_q     <= 1'b0;
      row_cnt_q <= 2'd0;
    end else begin
      state_q   <= state_d;
      vs_q      <= pix_if.per_frame_vsync;
      href_q    <= pix_if.per_frame_href;
      clken_q   <= pix_if.per_frame_clken;
      col_cnt_q <= col_cnt_d;
      ovf_q     <= ovf_d;
      row_cnt_q <= row_cnt_d;
      if (vs_rise) mode_q <= pix_if.morph_mode;
    end
  end

  // Stage 1: line buffers and window update
  always_ff @(posedge clk) begin
    if (pix && !ovf_cur) begin
      lb1_mem[col_cur] <= lb0_rd;
      lb0_mem[col_cur] <= pix_if.per_img_bit;
    end
    if (pix) begin
      win_top_q <= {lb1_rd, win_top_q[2:1]};
      win_mid_q <= {lb0_rd, win_mid_q[2:1]};
      win_bot_q <= {pix_if.per_img_bit, win_bot_q[2:1]};
      row_s1_q  <= row_cur;
      col_s1_q  <= (col_cur >= ADDR_W'(2)) ? 2'd2 : col_cur[1:0];
      ovf_s1_q  <= ovf_cur;
    end
    bit_s1_q  <= pix_if.per_img_bit & pix_if.per_frame_clken;
    mode_s1_q <= mode_q;
  end

  assign result = (mode_s1_q == 2'b00) ? bit_s1_q :
                  ovf_s1_q             ? 1'b0 :
                  morph_fn(win_top_q, win_mid_q, win_bot_q, row_s1_q, col_s1_q,
                           mode_s1_q == 2'b10);

  assign post_href_d  = href_q & active;
  assign post_clken_d = clken_q & active;
  assign post_bit_d   = post_clken_d & result;

  // Stage 2: registered result and delayed syncs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      post_vs_q    <= 1'b0;
      post_href_q  <= 1'b0;
      post_clken_q <= 1'b0;
      post_bit_q   <= 1'b0;
    end else begin
      post_vs_q    <= vs_q;
      post_href_q  <= post_href_d;
      post_clken_q <= post_clken_d;
      post_bit_q   <= post_bit_d;
    end
  end

  assign pix_if.post_frame_vsync = post_vs_q;
  assign pix_if.post_frame_href  = post_href_q;
  assign pix_if.post_frame_clken = post_clken_q;
  assign pix_if.post_img_bit     = post_bit_q;

endmodule

// File: tb/tb_canny_edge_morph_3x3.sv
// Directed bench for canny_edge_morph_3x3: 8x8 frames against a direct 2-D
// reference of the 3x3 op, plus bypass timing, mode latching and mid-frame reset.
module tb_canny_edge_morph_3x3;

  typedef bit img_t [0:7][0:7];

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;
  bit   capq [$];
  bit   byp_en = 1'b0;
  logic [3:0] h1 = 4'h0, h2 = 4'h0;

  always #5 clk = ~clk;

  canny_edge_morph_3x3_if bus ();

  canny_edge_morph_3x3 dut (
    .clk    (clk),
    .rst    (rst),
    .pix_if (bus)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Output pixel (r,c) covers input rows r-2..r, cols c-2..c; off-frame reads 0.
  function automatic bit model(input img_t im, input int mode, input int r, input int c);
    bit acc, v;
    int rr, cc;
    if (mode == 0) return im[r][c];
    acc = (mode == 2);
    for (int dr = 0; dr < 3; dr++)
      for (int dc = 0; dc < 3; dc++) begin
        rr = r - dr;
        cc = c - dc;
        v  = (rr >= 0 && cc >= 0) ? im[rr][cc] : 1'b0;
        if (mode == 2) acc = acc & v;
        else           acc = acc | v;
      end
    return acc;
  endfunction

  always @(negedge clk) begin
    if (bus.post_frame_clken) capq.push_back(bus.post_img_bit);
    if (byp_en) begin
      chk("byp_vsync", bus.post_frame_vsync, h2[3]);
      chk("byp_href",  bus.post_frame_href,  h2[2]);
      chk("byp_clken", bus.post_frame_clken, h2[1]);
      chk("byp_bit",   bus.post_img_bit,     h2[0]);
    end
    h2 = h1;
    h1 = {bus.per_frame_vsync, bus.per_frame_href, bus.per_frame_clken,
          bus.per_frame_clken & bus.per_img_bit};
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input img_t im, input bit gaps, input int sw_row,
                            input logic [1:0] sw_mode, input int rst_row, input int rst_col);
    capq.delete();
    bus.per_frame_vsync = 1'b1;
    cyc(2);
    bus.per_frame_vsync = 1'b0;
    cyc(3);
    for (int r = 0; r < 8; r++) begin
      if (r == sw_row) bus.morph_mode = sw_mode;
      bus.per_frame_href = 1'b1;
      for (int c = 0; c < 8; c++) begin
        if (r == rst_row && c == rst_col) begin
          rst = 1'b1;
          bus.per_frame_clken = 1'b0;
          bus.per_img_bit = 1'b0;
          @(negedge clk);
          chk("rst_vsync", bus.post_frame_vsync, 0);
          chk("rst_href",  bus.post_frame_href,  0);
          chk("rst_clken", bus.post_frame_clken, 0);
          chk("rst_bit",   bus.post_img_bit,     0);
          @(posedge clk);
          #1;
          rst = 1'b0;
        end
        if (gaps) begin
          bus.per_frame_clken = 1'b0;
          bus.per_img_bit = 1'b0;
          cyc(1);
        end
        bus.per_frame_clken = 1'b1;
        bus.per_img_bit = im[r][c];
        cyc(1);
      end
      bus.per_frame_clken = 1'b0;
      bus.per_img_bit = 1'b0;
      bus.per_frame_href = 1'b0;
      cyc(4);
    end
    cyc(4);
  endtask

  task automatic check_frame(input string tag, input img_t im, input int mode, input int n);
    chk({tag, "_count"}, capq.size(), n);
    for (int i = 0; i < n && i < capq.size(); i++)
      chk($sformatf("%s_px_r%0d_c%0d", tag, i / 8, i % 8), capq[i], model(im, mode, i / 8, i % 8));
  endtask

  function automatic int ones();
    int k = 0;
    foreach (capq[i]) k += capq[i];
    return k;
  endfunction

  img_t img1, img_all, img_rnd, img4;

  initial begin
    foreach (img1[r, c]) begin
      img1[r][c]    = (r == 5 && c == 5);
      img_all[r][c] = 1'b1;
      img_rnd[r][c] = 1'($urandom_range(0, 1));
      img4[r][c]    = (r >= 1 && r <= 6 && c >= 1 && c <= 6);
    end

    rst = 1'b1;
    bus.morph_mode      = 2'b01;
    bus.per_frame_vsync = 1'b0;
    bus.per_frame_href  = 1'b0;
    bus.per_frame_clken = 1'b0;
    bus.per_img_bit     = 1'b0;
    cyc(3);
    chk("reset_vsync", bus.post_frame_vsync, 0);
    chk("reset_href",  bus.post_frame_href,  0);
    chk("reset_clken", bus.post_frame_clken, 0);
    chk("reset_bit",   bus.post_img_bit,     0);
    rst = 1'b0;
    cyc(2);

    // A line before any vsync must be suppressed.
    capq.delete();
    bus.per_frame_href = 1'b1;
    bus.per_frame_clken = 1'b1;
    bus.per_img_bit = 1'b1;
    cyc(8);
    bus.per_frame_href = 1'b0;
    bus.per_frame_clken = 1'b0;
    bus.per_img_bit = 1'b0;
    cyc(4);
    chk("prevsync_count", capq.size(), 0);

    bus.morph_mode = 2'b01;
    send_frame(img1, 1'b0, -1, 2'b00, -1, -1);
    check_frame("dilate1", img1, 1, 64);
    chk("dilate1_ones", ones(), 9);

    bus.morph_mode = 2'b10;
    send_frame(img_all, 1'b0, -1, 2'b00, -1, -1);
    check_frame("erode_all", img_all, 2, 64);
    chk("erode_all_ones", ones(), 36);

    bus.morph_mode = 2'b00;
    byp_en = 1'b1;
    send_frame(img_rnd, 1'b0, -1, 2'b00, -1, -1);
    byp_en = 1'b0;
    check_frame("bypass", img_rnd, 0, 64);

    bus.morph_mode = 2'b01;
    send_frame(img4, 1'b0, 3, 2'b10, -1, -1);
    check_frame("modesw_dil", img4, 1, 64);
    send_frame(img4, 1'b0, -1, 2'b00, -1, -1);
    check_frame("modesw_ero", img4, 2, 64);
    chk("modesw_ero_ones", ones(), 16);

    bus.morph_mode = 2'b01;
    send_frame(img1, 1'b0, -1, 2'b00, 3, 4);
    check_frame("rstmid", img1, 1, 26);
    send_frame(img1, 1'b0, -1, 2'b00, -1, -1);
    check_frame("after_rst", img1, 1, 64);

    send_frame(img1, 1'b1, -1, 2'b00, -1, -1);
    check_frame("gaps", img1, 1, 64);
    chk("gaps_ones", ones(), 9);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
